rr_encoder8: RTL
================

Name: rr_encoder8

Overview:
- Registered 8-to-3 round-robin encoder. It is the inverse-direction companion of the 3-to-8 write-select decoder.
- Takes up to eight one-per-source request lines and selects one requester per transfer.
- Presents the winner as a 3-bit index plus a one-hot grant, through a valid/ready output register.
- Used wherever several units compete for a single write port. Its Idx output drives the write-select decoder's address input.

Parameters:
RR_EN, 1, 1 = round-robin priority (pointer advances past each winner); 0 = fixed priority, index 0 highest.

Ports:
clk    input   1  system clock, rising edge
rst    input   1  asynchronous reset, active-high
Req    input   8  request vector, bit i = source i requesting
Ready  input   1  consumer accepts current Idx/Grant this cycle
Valid  output  1  Idx/Grant hold a live selection
Idx    output  3  encoded index of the selected requester
Grant  output  8  one-hot of Idx while Valid=1, else 8'h00
Any    output  1  combinational OR of Req (no register)

Behaviour:
- Reset (async, rst=1): Valid=0, Idx=3'd0, Grant=8'h00, internal pointer Ptr=3'd0. These values apply immediately and hold while rst=1.
- Reset asserted mid-transfer discards the pending selection. No grant survives reset.
- Load condition: Load = ~Valid | Ready, evaluated each rising clk edge.
- Selection (combinational): scan Req starting at bit Ptr, then Ptr+1, ... wrapping 7->0. The first set bit is sel.
- With RR_EN=0, Ptr is held at 0, so the lowest set bit wins.
- Edge with Load=1 and Req!=0:
  - Valid<=1, Idx<=sel, Grant<=1<<sel.
  - If RR_EN=1, Ptr<=sel+1 mod 8 (sel=7 wraps to 0).
- Edge with Load=1 and Req==0:
  - Valid<=0, Grant<=8'h00.
  - Idx and Ptr hold their previous values.
- Edge with Load=0 (Valid=1, Ready=0), the stall case:
  - Valid, Idx, Grant and Ptr all hold.
  - Req changes are ignored, including withdrawal of the granted request.
- Latency: Req sampled at edge N appears on Idx/Valid after edge N. One cycle, no combinational Req->Idx path.
- Back-to-back operation: with Ready=1 continuously, a new selection is loaded every cycle, giving full throughput.
- Same-edge acceptance and reload: Valid=1 with Ready=1 accepts the current item and loads the next in the same edge. No bubble is inserted.
- Fairness: with all 8 requests held and Ready=1, each index is granted exactly once in any 8 consecutive transfers.
- Requesters are not masked by the block. A source that keeps Req set after its grant is re-eligible after the pointer passes it.
- Any = |Req, purely combinational, independent of Ready/Valid.

Decomposition:
- Shared constants header holds N_SRC=8 and IDX_W=3. The write-select decoder uses the same constants.
- One sub-module, pri_enc8: a combinational 8-to-3 fixed-priority encoder (In[7:0] -> Out[2:0], V). Lowest set bit wins.
- The top level builds the round-robin selection from pri_enc8:
  - rotate Req right by Ptr;
  - encode the rotated vector with pri_enc8;
  - sel = enc + Ptr mod 8.
- The top level also contains the output/pointer registers and the Grant one-hot generation.

Test Plan:
1. Reset: assert rst asynchronously with Req=8'hFF, Ready=1 -> Valid=0, Idx=0, Grant=8'h00 immediately, without waiting for a clock edge. Deassert rst; first edge -> Idx=0, Grant=8'h01.
2. Round-robin sweep (RR_EN=1): Req=8'hFF, Ready=1 for 9 cycles -> Idx sequence 0,1,2,3,4,5,6,7,0.
3. Wrap and skip: Ptr=6 (after a grant of 5), Req=8'b0000_0101 -> Idx=0, Grant=8'h01. Next edge -> Idx=2, Grant=8'h04.
4. Stall: Valid=1, Idx=3, then Ready=0 for 3 cycles while Req changes to 8'h80 -> Idx stays 3, Grant stays 8'h08. Raise Ready -> next edge Idx=7.
5. Empty: Req=8'h00, Ready=1 -> Valid=0, Grant=8'h00, Any=0, Idx holds its last value. Req=8'h10 -> Any=1 same cycle; Valid=1, Idx=4 after the next edge.
6. Fixed priority (RR_EN=0): Req=8'b1010_0000 held, Ready=1, for 4 cycles -> Idx=5 every cycle and never 7.

Source files
------------

// File: rtl/rr_encoder8_pkg.sv
// Shared sizing constants for the write-port encoder/decoder pair.
package rr_encoder8_pkg;

    localparam int N_SRC = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [N_SRC-1:0] vec_t;

    function automatic vec_t onehot(input idx_t idx);
        return vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_encoder8_pri_enc8.sv
// Combinational 8-to-3 fixed-priority encoder; the lowest set bit wins.
module pri_enc8
    import rr_encoder8_pkg::*;
(
    input  logic [N_SRC-1:0] In,
    output logic [IDX_W-1:0] Out,
    output logic             V
);

    always_comb begin
        Out = '0;
        V   = |In;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (In[i]) begin
                Out = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_encoder8.sv
// Registered 8-to-3 round-robin encoder with a valid/ready output register.
module rr_encoder8
    import rr_encoder8_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] Req,
    input  logic             Ready,
    output logic             Valid,
    output logic [IDX_W-1:0] Idx,
    output logic [N_SRC-1:0] Grant,
    output logic             Any
);

    logic             valid_q, valid_d;
    idx_t             idx_q, idx_d;
    vec_t             grant_q, grant_d;
    idx_t             ptr_q, ptr_d;

    logic [2*N_SRC-1:0] req_dbl;
    vec_t               req_rot;
    idx_t               enc;
    logic               enc_v;
    idx_t               sel;
    logic               load;

    // Rotating right by the pointer lets a plain priority encoder do the round-robin scan.
    assign req_dbl = {Req, Req};
    assign req_rot = N_SRC'(req_dbl >> ptr_q);

    pri_enc8 u_pri_enc8 (
        .In  (req_rot),
        .Out (enc),
        .V   (enc_v)
    );

    assign sel  = enc + ptr_q;
    assign load = ~valid_q | Ready;
    assign Any  = |Req;

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (enc_v) begin
                valid_d = 1'b1;
                idx_d   = sel;
                grant_d = onehot(sel);
                if (RR_EN) begin
                    ptr_d = sel + idx_t'(1);
                end
            end else begin
                valid_d = 1'b0;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Valid = valid_q;
    assign Idx   = idx_q;
    assign Grant = grant_q;

endmodule
